// File: rtl/riscv_cpu_pkg.sv
// Shared types and constants for the CPU core's branch redirect logic.
//   br_state_e             : redirect controller states
//   BR_FLUSH_DEPTH_DEFAULT : default number of younger pipeline registers to squash
//   INSTR_ALIGN_MASK       : low target bits that must be zero for a word-aligned PC
package riscv_cpu_pkg;

    typedef enum logic [1:0] {
        BR_IDLE     = 2'd0,
        BR_REDIRECT = 2'd1,
        BR_DRAIN    = 2'd2
    } br_state_e;

    localparam int unsigned BR_FLUSH_DEPTH_DEFAULT = 3;

    localparam logic [1:0] INSTR_ALIGN_MASK = 2'b11;

    // True when the low bits of a branch target break word alignment.
    function automatic logic is_misaligned(input logic [1:0] addr_lo);
        return (addr_lo & INSTR_ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/branch_redirect_ctl_perf_counter.sv
// perf_counter: 32-bit event counter that wraps modulo 2^32.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset, clears the count
//   inc_i   : add one this cycle
//   count_o : registered count
module perf_counter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inc_i,
    output logic [31:0] count_o
);

    logic [31:0] count_r;

    // Count register; natural 32-bit overflow gives the wrap to zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_r <= 32'd0;
        end else if (inc_i) begin
            count_r <= count_r + 32'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign count_o = count_r;

endmodule

// File: rtl/branch_redirect_ctl.sv
// branch_redirect_ctl: turns a branch resolved in MEM into a redirect request
// for fetch, squashes the younger pipeline registers, holds the pipeline until
// fetch accepts the new PC, then lets the wrong-path slots drain before the
// next branch is accepted. Also counts resolved and taken branches.
//   clk_i, rst_i             : clock, synchronous active-high reset
//   branch_valid_i, taken_i  : MEM-stage branch and its taken decision
//   target_i, stall_i        : resolved target; MEM stall (branch not consumed)
//   redirect_valid_o/pc_o    : registered redirect request to fetch
//   redirect_ready_i         : fetch accepts the redirect
//   flush_o                  : per-stage squash, bit 0 = IF/ID
//   hold_o                   : freeze pipeline register enables
//   misalign_o               : one-cycle pulse for a misaligned taken target
//   branch_cnt_o/taken_cnt_o : performance counters
module branch_redirect_ctl
    import riscv_cpu_pkg::*;
#(
    parameter int unsigned FLUSH_DEPTH = BR_FLUSH_DEPTH_DEFAULT
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   branch_valid_i,
    input  logic                   taken_i,
    input  logic [31:0]            target_i,
    input  logic                   stall_i,
    output logic                   redirect_valid_o,
    output logic [31:0]            redirect_pc_o,
    input  logic                   redirect_ready_i,
    output logic [FLUSH_DEPTH-1:0] flush_o,
    output logic                   hold_o,
    output logic                   misalign_o,
    output logic [31:0]            branch_cnt_o,
    output logic [31:0]            taken_cnt_o
);

    localparam logic [2:0]             DRAIN_LOAD = 3'(FLUSH_DEPTH - 1);
    localparam logic [FLUSH_DEPTH-1:0] FLUSH_ALL  = {FLUSH_DEPTH{1'b1}};

    br_state_e              state_r, state_nx_s;
    logic [2:0]             drain_cnt_r, drain_cnt_nx_s;
    logic [31:0]            redirect_pc_r, redirect_pc_nx_s;
    logic [FLUSH_DEPTH-1:0] flush_r, flush_nx_s;
    logic                   redirect_valid_r, hold_r, misalign_r, misalign_nx_s;
    logic                   consume_s, taken_s;

    // A branch is only accepted while idle and not stalled; wrong-path
    // branches seen during REDIRECT/DRAIN are dropped here.
    assign consume_s = (state_r == BR_IDLE) & branch_valid_i & ~stall_i;
    assign taken_s   = consume_s & taken_i;

    // Next-state and next-output logic.
    always_comb begin
        state_nx_s       = state_r;
        drain_cnt_nx_s   = drain_cnt_r;
        redirect_pc_nx_s = redirect_pc_r;
        flush_nx_s       = '0;
        misalign_nx_s    = 1'b0;
        case (state_r)
            BR_IDLE: begin
                if (taken_s) begin
                    flush_nx_s = FLUSH_ALL;
                    if (is_misaligned(target_i[1:0])) begin
                        // Trap path owns recovery; only squash and drain.
                        misalign_nx_s  = 1'b1;
                        state_nx_s     = BR_DRAIN;
                        drain_cnt_nx_s = DRAIN_LOAD;
                    end else begin
                        redirect_pc_nx_s = target_i;
                        state_nx_s       = BR_REDIRECT;
                    end
                end else begin
                    state_nx_s = BR_IDLE;
                end
            end
            BR_REDIRECT: begin
                // redirect_valid_o is always high here, so ready alone completes the handshake.
                if (redirect_ready_i) begin
                    state_nx_s     = BR_DRAIN;
                    drain_cnt_nx_s = DRAIN_LOAD;
                end else begin
                    state_nx_s = BR_REDIRECT;
                end
            end
            BR_DRAIN: begin
                // Leave as the counter steps to zero; a zero load leaves after one cycle.
                if (drain_cnt_r <= 3'd1) begin
                    state_nx_s     = BR_IDLE;
                    drain_cnt_nx_s = 3'd0;
                end else begin
                    drain_cnt_nx_s = drain_cnt_r - 3'd1;
                end
            end
            default: begin
                state_nx_s     = BR_IDLE;
                drain_cnt_nx_s = 3'd0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any redirect in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r          <= BR_IDLE;
            drain_cnt_r      <= 3'd0;
            redirect_pc_r    <= 32'd0;
            redirect_valid_r <= 1'b0;
            hold_r           <= 1'b0;
            flush_r          <= '0;
            misalign_r       <= 1'b0;
        end else begin
            state_r          <= state_nx_s;
            drain_cnt_r      <= drain_cnt_nx_s;
            redirect_pc_r    <= redirect_pc_nx_s;
            redirect_valid_r <= (state_nx_s == BR_REDIRECT);
            hold_r           <= (state_nx_s == BR_REDIRECT);
            flush_r          <= flush_nx_s;
            misalign_r       <= misalign_nx_s;
        end
    end

    perf_counter u_branch_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (consume_s),
        .count_o (branch_cnt_o)
    );

    perf_counter u_taken_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (taken_s),
        .count_o (taken_cnt_o)
    );

    assign redirect_valid_o = redirect_valid_r;
    assign redirect_pc_o    = redirect_pc_r;
    assign hold_o           = hold_r;
    assign flush_o          = flush_r;
    assign misalign_o       = misalign_r;

endmodule
